data_register_arbiter: RTL and testbench
========================================

# data_register_arbiter

Two-port arbiter and sequencer for the 16-entry x 16-bit operand data register. It shares one register bank between port 0 (CPU operand fetch) and port 1 (loader/debug writer), serialising their read and write transactions. Each transaction completes with a registered `done` pulse, and reads also return data. The block sits between the control unit/loader and the accumulator datapath, and owns the storage.

## Interface

- `DATA_W`, 16, data word width
- `ADDR_W`, 4, address width; depth = 2**ADDR_W
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `p0_req`  in  1  port 0 request; held with fields stable until `p0_gnt`
- `p0_we`  in  1  port 0: 1 = write, 0 = read
- `p0_addr`  in  ADDR_W  port 0 address
- `p0_wdata`  in  DATA_W  port 0 write data
- `p0_gnt`  out  1  one-cycle grant pulse; request fields captured this cycle
- `p0_done`  out  1  one-cycle completion pulse
- `p0_rdata`  out  DATA_W  read data; valid when `p0_done` is high for a read, held otherwise
- `p1_*`  same set as `p0_*`, for port 1
- `busy`  out  1  high in ACCESS and RESP

## Operation

- Storage: 2**ADDR_W x DATA_W array, not cleared by reset.
  - Power-up contents: [0]=0x000A, [1]=0x000F, [2]=0x0010, [3]=0x0008, [4]=0x00FF, [5]=0x000F, [6]=0x000A, others 0x0000.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any `req` is high, arbitrate, pulse the winner's `gnt`, capture `we`/`addr`/`wdata`/port id, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: a write updates the array at the clock edge that ends ACCESS. A read latches `array[addr]` into the winner's `rdata` register at the same edge. Go to RESP.
  - RESP: winner's `done`=1. If any `req` is high, arbitrate and pulse `gnt` in this same cycle, then go to ACCESS. Otherwise go to IDLE.
- Requests are sampled only in IDLE and RESP. A `req` dropped before its grant is ignored with no side effects.
- The requester must deassert `req` on the cycle after `gnt`, or hold it for a new transaction. A held `req` means another request and is granted again.
- Arbitration (default build): fixed priority, port 0 wins.
- `rdata` of the non-winning port is unchanged. Write transactions leave `rdata` unchanged.
- A read following a write to the same address returns the new data, because transactions are strictly serialised.
- Only ACCESS/RESP/IDLE exist; there is no error state. All addresses are in range by width.

## Timing

- Reset values: state=IDLE; `p0_gnt`=`p1_gnt`=`p0_done`=`p1_done`=`busy`=0; `p0_rdata`=`p1_rdata`=0; round-robin pointer=port 0.
- Latency: `req` seen in cycle N (IDLE) gives `gnt` in cycle N, ACCESS in N+1, `done`/`rdata` in N+2.
- `gnt` is combinational from state and `req`; `done` and `rdata` are registered.
- Back-to-back throughput: one transaction every 2 cycles (RESP chains into ACCESS).
- Simultaneous requests in one cycle: exactly one `gnt` is asserted. Both `gnt` signals are never high together, nor are both `done` signals.
- Reset asserted mid-operation (ACCESS or RESP): returns to IDLE immediately.
  - An ACCESS write whose ending edge coincides with reset is suppressed.
  - No `done` is issued for the aborted transaction.

## Configuration

- `DATA_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port and flips to the other port after every grant.
  - On a tie the preferred port wins; a single requester always wins.
- Not defined: fixed priority, port 0 always wins ties. The pointer logic is absent.

## Structure

- Package `data_register_pkg`: FSM state enum (IDLE, ACCESS, RESP), port id type, default `DATA_W`/`ADDR_W` constants, power-up contents constants.
- Sub-module `data_register_bank`: synchronous-write, combinational-read array with power-up contents. The arbiter FSM and grant logic stay in the top.

## Test plan

- Single read: `p0_req`, `we`=0, `addr`=4 -> `p0_gnt` in cycle 0, `p0_done`=1 with `p0_rdata`=0x00FF in cycle 2, `busy` high in cycles 1-2.
- Write then read: p1 writes 0x1234 to addr 9, then p1 reads addr 9 -> second `p1_done` carries `p1_rdata`=0x1234; `p0_rdata` stays 0.
- Contention: `p0_req` and `p1_req` high together for 4 transactions, reads of addrs 0 and 1 respectively.
  - Default build: grants are p0,p0,p0,p0 while p0 is held.
  - With `DATA_ARB_ROUND_ROBIN_EN`: p0,p1,p0,p1, with `rdata` 0x000A/0x000F.
- Back-to-back: p0 holds `req` for 3 reads -> `done` pulses every 2 cycles, `gnt` coincides with the previous `done`.
- Reset mid-write: `rst_n` low during ACCESS of a p0 write of 0xBEEF to addr 2 -> no `done`, outputs at reset values; a later read of addr 2 returns 0x0010.
- Withdrawn request: `p1_req` pulsed for one cycle while the FSM is in ACCESS -> no `p1_gnt` or `p1_done`; memory unchanged.

Source files
------------

// File: rtl/data_register_pkg.sv
// Shared types and constants for the operand data register arbiter.
package data_register_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int NUM_PORTS  = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef logic port_t;

  // Power-up image, entry 0 in the low word; entries 7 and up are zero.
  localparam logic [7:0][15:0] INIT_IMAGE = {
    16'h0000, 16'h000A, 16'h000F, 16'h00FF,
    16'h0008, 16'h0010, 16'h000F, 16'h000A
  };

  function automatic logic [15:0] init_word(input int idx);
    if (idx >= 0 && idx < 8) return INIT_IMAGE[idx[2:0]];
    return 16'h0000;
  endfunction

endpackage

// File: rtl/data_register_bank.sv
// Operand register array: synchronous write, combinational read, power-up image.
module data_register_bank
  import data_register_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  function automatic logic [DEPTH-1:0][DATA_W-1:0] power_up_image();
    logic [DEPTH-1:0][DATA_W-1:0] img;
    for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'(init_word(i));
    return img;
  endfunction

  localparam logic [DEPTH-1:0][DATA_W-1:0] IMAGE = power_up_image();

  // Cells hold the difference from the image, so an all-zero array reads back
  // the power-up contents without any reset or load sequence.
  logic [DEPTH-1:0][DATA_W-1:0] diff;

  always_ff @(posedge clk)
    if (we) diff[waddr] <= wdata ^ IMAGE[waddr];

  assign rdata = diff[raddr] ^ IMAGE[raddr];

endmodule

// File: rtl/data_register_arbiter.sv
// Two-port arbiter/sequencer owning the operand data register bank.
// DATA_ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority to port 0.
module data_register_arbiter
  import data_register_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              busy
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    port_t             port;
  } req_t;

  state_t                               state;
  req_t                                 cap, sel;
  req_t  [NUM_PORTS-1:0]                port_req;
  logic  [NUM_PORTS-1:0]                req, gnt, done;
  logic  [NUM_PORTS-1:0][DATA_W-1:0]    rdata;
  logic  [DATA_W-1:0]                   rd_word;
  logic                                 sample, wr_en;
  port_t                                win;

  assign port_req[0] = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, port: 1'b0};
  assign port_req[1] = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, port: 1'b1};
  assign req         = {p1_req, p0_req};
  assign sample      = (state == IDLE) || (state == RESP);

`ifdef DATA_ARB_ROUND_ROBIN_EN
  port_t ptr;

  assign win = (&req) ? ptr : ~req[0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    ptr <= 1'b0;
    else if (|gnt) ptr <= ~win;
`else
  assign win = ~req[0];
`endif

  always_comb begin
    gnt = '0;
    if (sample && req[win]) gnt[win] = 1'b1;
  end

  assign sel = port_req[win];

  // Gate with rst_n so a write whose closing edge lands in reset is dropped.
  assign wr_en = (state == ACCESS) && cap.we && rst_n;

  data_register_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .we    (wr_en),
    .waddr (cap.addr),
    .wdata (cap.wdata),
    .raddr (cap.addr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cap   <= '0;
      done  <= '0;
      rdata <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE, RESP: begin
          if (|req) begin
            cap   <= sel;
            state <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          done[cap.port] <= 1'b1;
          if (!cap.we) rdata[cap.port] <= rd_word;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_gnt   = gnt[0];
  assign p1_gnt   = gnt[1];
  assign p0_done  = done[0];
  assign p1_done  = done[1];
  assign p0_rdata = rdata[0];
  assign p1_rdata = rdata[1];
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_data_register_arbiter.sv
// Directed bench for data_register_arbiter with a grant-to-done scoreboard.
module tb_data_register_arbiter;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic          p0_gnt, p0_done, p1_gnt, p1_done, busy;

  always #5 clk = ~clk;

  data_register_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .busy(busy)
  );

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gcyc;
  } txn_t;

  txn_t          sbq[$];
  logic [DW-1:0] mmem [16];
  logic [DW-1:0] mrd  [2];
  int            tests = 0;
  int            fails = 0;
  int            cyc_n = 0;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Scoreboard: a grant queues the transaction, the matching done retires it
  // against the bench's own memory image.
  txn_t       t_m;
  logic [1:0] dv, gv;
  always @(negedge clk) begin
    if (rst_n) begin
      dv = {p1_done, p0_done};
      gv = {p1_gnt, p0_gnt};
      chk_b("gnt_exclusive", &gv, 1'b0);
      chk_b("done_exclusive", &dv, 1'b0);
      for (int p = 0; p < 2; p++) begin
        if (dv[p]) begin
          if (sbq.size() == 0) chk_b("unexpected_done", 1'b1, 1'b0);
          else begin
            t_m = sbq.pop_front();
            chk_w("sb_port", 16'(p), 16'(t_m.port));
            chk_w("sb_latency", 16'(cyc_n), 16'(t_m.gcyc + 2));
            if (t_m.we) mmem[t_m.addr] = t_m.wdata;
            else        mrd[p] = mmem[t_m.addr];
          end
        end
      end
      chk_w("sb_rdata0", p0_rdata, mrd[0]);
      chk_w("sb_rdata1", p1_rdata, mrd[1]);
      for (int p = 0; p < 2; p++) begin
        if (gv[p]) begin
          t_m.port  = p;
          t_m.we    = (p == 0) ? p0_we    : p1_we;
          t_m.addr  = (p == 0) ? p0_addr  : p1_addr;
          t_m.wdata = (p == 0) ? p0_wdata : p1_wdata;
          t_m.gcyc  = cyc_n;
          sbq.push_back(t_m);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    p0_req = 1'b0;
    p1_req = 1'b0;
    sbq.delete();
    mrd[0] = '0;
    mrd[1] = '0;
    @(negedge clk);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_gnt0", p0_gnt, 1'b0);
    chk_b("rst_gnt1", p1_gnt, 1'b0);
    chk_b("rst_done0", p0_done, 1'b0);
    chk_b("rst_done1", p1_done, 1'b0);
    chk_w("rst_rdata0", p0_rdata, 16'h0000);
    chk_w("rst_rdata1", p1_rdata, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;
    for (int i = 0; i < 16; i++) mmem[i] = '0;
    mmem[0] = 16'h000A; mmem[1] = 16'h000F; mmem[2] = 16'h0010; mmem[3] = 16'h0008;
    mmem[4] = 16'h00FF; mmem[5] = 16'h000F; mmem[6] = 16'h000A;
    p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    do_reset();

    // Port 1 write 0x1234 to 9, then read it back.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 4'd9; p1_wdata = 16'h1234;
    @(negedge clk); chk_b("wr_gnt1", p1_gnt, 1'b1); chk_b("wr_gnt0", p0_gnt, 1'b0);
    cyc(); p1_req = 1'b0;
    cyc(); @(negedge clk); chk_b("wr_done1", p1_done, 1'b1); chk_w("wr_rdata1", p1_rdata, 16'h0000);
    cyc(); p1_req = 1'b1; p1_we = 1'b0;
    @(negedge clk); chk_b("rb_gnt1", p1_gnt, 1'b1);
    cyc(); p1_req = 1'b0;
    cyc(); @(negedge clk);
    chk_b("rb_done1", p1_done, 1'b1); chk_w("rb_rdata1", p1_rdata, 16'h1234);
    chk_w("rb_rdata0", p0_rdata, 16'h0000);
    cyc();

    // Single read of address 4 on port 0.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 4'd4;
    @(negedge clk); chk_b("rd_gnt0", p0_gnt, 1'b1); chk_b("rd_busy_c0", busy, 1'b0);
    cyc(); p0_req = 1'b0;
    @(negedge clk); chk_b("rd_busy_c1", busy, 1'b1); chk_b("rd_done_c1", p0_done, 1'b0);
    cyc(); @(negedge clk);
    chk_b("rd_done_c2", p0_done, 1'b1); chk_w("rd_rdata0", p0_rdata, 16'h00FF);
    chk_b("rd_busy_c2", busy, 1'b1);
    cyc(); @(negedge clk); chk_b("rd_busy_c3", busy, 1'b0); chk_b("rd_done_c3", p0_done, 1'b0);

    // Back-to-back: port 0 holds req for three reads of address 5.
    cyc(); p0_req = 1'b1; p0_addr = 4'd5;
    @(negedge clk); chk_b("b2b_gnt_c0", p0_gnt, 1'b1);
    cyc(); cyc(); @(negedge clk);
    chk_b("b2b_done_c2", p0_done, 1'b1); chk_b("b2b_gnt_c2", p0_gnt, 1'b1);
    cyc(); cyc(); @(negedge clk);
    chk_b("b2b_done_c4", p0_done, 1'b1); chk_b("b2b_gnt_c4", p0_gnt, 1'b1);
    cyc(); p0_req = 1'b0;
    @(negedge clk); chk_b("b2b_done_c5", p0_done, 1'b0);
    cyc(); @(negedge clk);
    chk_b("b2b_done_c6", p0_done, 1'b1); chk_w("b2b_rdata", p0_rdata, 16'h000F);
    chk_b("b2b_gnt_c6", p0_gnt, 1'b0);
    cyc();

    // Port 1 request withdrawn while the FSM is in ACCESS.
    p0_req = 1'b1; p0_addr = 4'd6;
    @(negedge clk); chk_b("wd_gnt0", p0_gnt, 1'b1);
    cyc(); p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b1; p1_addr = 4'd7; p1_wdata = 16'h5555;
    @(negedge clk); chk_b("wd_gnt1_acc", p1_gnt, 1'b0);
    cyc(); p1_req = 1'b0;
    @(negedge clk);
    chk_b("wd_gnt1_resp", p1_gnt, 1'b0); chk_b("wd_done0", p0_done, 1'b1);
    chk_w("wd_rdata0", p0_rdata, 16'h000A); chk_b("wd_done1", p1_done, 1'b0);
    cyc(); @(negedge clk); chk_b("wd_done1_late", p1_done, 1'b0); chk_b("wd_idle", busy, 1'b0);
    cyc(); p0_req = 1'b1; p0_addr = 4'd7;
    @(negedge clk); chk_b("wd_chk_gnt", p0_gnt, 1'b1);
    cyc(); p0_req = 1'b0;
    cyc(); @(negedge clk); chk_w("wd_mem7", p0_rdata, 16'h0000);
    cyc();

    // Reset during ACCESS of a write of 0xBEEF to address 2.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 4'd2; p0_wdata = 16'hBEEF;
    @(negedge clk); chk_b("rw_gnt0", p0_gnt, 1'b1);
    cyc(); p0_req = 1'b0;
    @(negedge clk); chk_b("rw_busy_acc", busy, 1'b1);
    rst_n = 1'b0;
    sbq.delete(); mrd[0] = '0; mrd[1] = '0;
    #1;
    chk_b("rw_busy_rst", busy, 1'b0); chk_b("rw_done_rst", p0_done, 1'b0);
    @(posedge clk); @(negedge clk);
    chk_b("rw_done_after", p0_done, 1'b0); chk_w("rw_rdata_after", p0_rdata, 16'h0000);
    chk_b("rw_busy_after", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 4'd2;
    @(negedge clk); chk_b("rw_rd_gnt", p0_gnt, 1'b1);
    cyc(); p0_req = 1'b0;
    cyc(); @(negedge clk); chk_b("rw_rd_done", p0_done, 1'b1); chk_w("rw_mem2", p0_rdata, 16'h0010);
    cyc();

    // Contention from a fresh reset: both ports hold read requests.
    do_reset();
`ifdef DATA_ARB_ROUND_ROBIN_EN
    e = 4'b1010;
`else
    e = 4'b0000;
`endif
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 4'd0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 4'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_b($sformatf("cont_gnt0_%0d", i), p0_gnt, ~e[i]);
      chk_b($sformatf("cont_gnt1_%0d", i), p1_gnt, e[i]);
      if (i > 0) begin
        chk_b($sformatf("cont_done0_%0d", i), p0_done, ~e[i-1]);
        chk_b($sformatf("cont_done1_%0d", i), p1_done, e[i-1]);
      end
      cyc();
      if (i == 3) begin
        p0_req = 1'b0;
        p1_req = 1'b0;
      end
      cyc();
    end
    @(negedge clk);
    chk_b("cont_done0_last", p0_done, ~e[3]);
    chk_b("cont_done1_last", p1_done, e[3]);
    chk_w("cont_rdata0", p0_rdata, 16'h000A);
`ifdef DATA_ARB_ROUND_ROBIN_EN
    chk_w("cont_rdata1", p1_rdata, 16'h000F);
`else
    chk_w("cont_rdata1", p1_rdata, 16'h0000);
`endif
    cyc(); @(negedge clk); chk_b("cont_idle", busy, 1'b0);

    chk_w("sb_drained", 16'(sbq.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
